// File: rtl/bram_port_ctrl_pkg.sv
// Shared defaults and sizing helpers for the BRAM port controller and its response FIFO.
package bram_port_ctrl_pkg;

    localparam int unsigned DefAddrWidth = 16;
    localparam int unsigned DefDataWidth = 32;
    localparam int unsigned DefRspDepth  = 2;

    // Occupancy counter must represent 0..depth inclusive.
    function automatic int unsigned occ_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/bram_port_ctrl_rsp_fifo.sv
// Response buffer for bram_port_ctrl: synchronous FIFO with wrap-modulo-DEPTH pointers
// and an explicit occupancy counter. Storage is not reset.
module bram_rsp_fifo
    import bram_port_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = DefRspDepth,
    parameter int unsigned WIDTH = DefDataWidth
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_push,
    input  logic [WIDTH-1:0]               i_wdata,
    input  logic                           i_pop,
    output logic [WIDTH-1:0]               o_rdata,
    output logic                           o_full,
    output logic                           o_empty,
    output logic [occ_width(DEPTH)-1:0]    o_count
);

    localparam int unsigned CntW = occ_width(DEPTH);
    localparam int unsigned PtrW = ptr_width(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PtrW-1:0]  r_wptr;
    logic [PtrW-1:0]  r_rptr;
    logic [CntW-1:0]  r_count;

    logic             w_do_push;
    logic             w_do_pop;
    logic [PtrW-1:0]  w_wptr_next;
    logic [PtrW-1:0]  w_rptr_next;

    assign o_full  = (r_count == CntW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rptr];

    // A push into a full buffer is only legal when the head leaves in the same cycle.
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    assign w_wptr_next = (r_wptr == PtrW'(DEPTH - 1)) ? '0 : r_wptr + PtrW'(1);
    assign w_rptr_next = (r_rptr == PtrW'(DEPTH - 1)) ? '0 : r_rptr + PtrW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= w_wptr_next;
            end
            if (w_do_pop) begin
                r_rptr <= w_rptr_next;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CntW'(1);
                2'b01:   r_count <= r_count - CntW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

endmodule

// File: rtl/bram_port_ctrl.sv
// Request/response front end for a 1-cycle-latency BRAM port. Every accepted request yields
// one in-order response; writes return the word that was overwritten.
module bram_port_ctrl
    import bram_port_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DefAddrWidth,
    parameter int unsigned DATA_WIDTH = DefDataWidth,
    parameter int unsigned RSP_DEPTH  = DefRspDepth
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [DATA_WIDTH/8-1:0] req_we,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    bram_en,
    output logic [DATA_WIDTH/8-1:0] bram_we,
    output logic [ADDR_WIDTH-1:0]   bram_addr,
    output logic [DATA_WIDTH-1:0]   bram_wdata,
    input  logic [DATA_WIDTH-1:0]   bram_rdata
);

    localparam int unsigned CntW = occ_width(RSP_DEPTH);

    logic                  r_inflight;
    logic                  w_accept;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;
    logic [CntW-1:0]       w_count;
    logic [CntW:0]         w_pending;
    logic [DATA_WIDTH-1:0] w_head;

    assign rsp_valid = !rst && !w_empty;
    assign rsp_rdata = w_head;
    assign w_pop     = rsp_valid && rsp_ready;

    // Slots committed next cycle: buffered + the read in flight, less the one leaving now.
    assign w_pending = (CntW + 1)'(w_count) + (CntW + 1)'(r_inflight) - (CntW + 1)'(w_pop);

    always_comb begin
        req_ready = 1'b0;
        if (rst) begin
            req_ready = 1'b0;
        end else if (w_full) begin
            // A full buffer only frees a slot on a pop with nothing already in flight.
            req_ready = w_pop && !r_inflight;
        end else begin
            req_ready = (w_pending < (CntW + 1)'(RSP_DEPTH));
        end
    end

    assign w_accept   = req_valid && req_ready;
    assign bram_en    = w_accept;
    assign bram_we    = w_accept ? req_we : '0;
    assign bram_addr  = req_addr;
    assign bram_wdata = req_wdata;

    // Read data from the previous accept is valid on bram_rdata now; capture it at this edge.
    assign w_push = r_inflight && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_accept;
        end
    end

    bram_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_rsp_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata (bram_rdata),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

endmodule
